// File: rtl/wait_state_ram_pkg.sv
// Shared constants for the wait-state data RAM: reset polarity, default widths
// and the access FSM encodings.
package wait_state_ram_pkg;

  localparam logic RstEnable    = 1'b0;
  localparam int   RegDataWidth = 32;
  localparam int   MemAddrWidth = 32;

  localparam int MemStateWidth = 2;
  localparam logic [MemStateWidth-1:0] IDLE = 2'b00;
  localparam logic [MemStateWidth-1:0] WAIT = 2'b01;
  localparam logic [MemStateWidth-1:0] DONE = 2'b10;

  // Default wait-counter width when a block does not size it from its latencies.
  localparam int MemLatencyWidth = 8;

  typedef enum logic {
    OpRead  = 1'b0,
    OpWrite = 1'b1
  } mem_op_e;

  // The counter only ever holds latency-1, so clog2 of the larger latency suffices.
  function automatic int latency_cnt_width(input int rd_lat, input int wr_lat);
    int max_lat;
    max_lat = (rd_lat > wr_lat) ? rd_lat : wr_lat;
    return (max_lat > 1) ? $clog2(max_lat) : 1;
  endfunction

endpackage

// File: rtl/wait_state_ram_wait_counter.sv
// Loadable down-counter used to time memory wait states; reusable for ROM models.
module wait_state_ram_wait_counter
  import wait_state_ram_pkg::*;
#(
  parameter int Width = MemLatencyWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [Width-1:0] value_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/wait_state_ram.sv
// Single-port data RAM with independent read/write wait states, ready/busy
// handshake and out-of-range error reporting.
//   state | meaning
//   IDLE  | waiting for ce/we; request captured on acceptance
//   WAIT  | counting down wait states; access performed when count hits 0
//   DONE  | one-cycle ready_o pulse, err_o valid
module wait_state_ram
  import wait_state_ram_pkg::*;
#(
  parameter int DataWidth    = RegDataWidth,
  parameter int Lanes        = DataWidth / 8,
  parameter int Depth        = 1024,
  parameter int AddrWidth    = MemAddrWidth,
  parameter int ReadLatency  = 2,
  parameter int WriteLatency = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 we,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic [Lanes-1:0]     byte_slct,
  output logic [DataWidth-1:0] data_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int LaneShift = (Lanes > 1) ? $clog2(Lanes) : 0;
  localparam int IdxWidth  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntWidth  = latency_cnt_width(ReadLatency, WriteLatency);

  localparam logic [CntWidth-1:0] RdLoad = CntWidth'(ReadLatency - 1);
  localparam logic [CntWidth-1:0] WrLoad = CntWidth'(WriteLatency - 1);

  logic [MemStateWidth-1:0] state_q, state_d;
  mem_op_e                  op_q;
  logic [IdxWidth-1:0]      widx_q;
  logic                     in_range_q;
  logic [DataWidth-1:0]     wdata_q;
  logic [Lanes-1:0]         bslct_q;
  logic [DataWidth-1:0]     rdata_q;
  logic [DataWidth-1:0]     mem_q [Depth];

  logic [AddrWidth-1:0] word_idx;
  logic                 addr_ok;
  logic                 accept;
  logic                 access;
  logic                 cnt_zero;
  logic [CntWidth-1:0]  cnt_load;

  assign word_idx = addr_i >> LaneShift;
  assign addr_ok  = (word_idx < AddrWidth'(Depth));
  assign accept   = (state_q == IDLE) && (ce || we);
  assign access   = (state_q == WAIT) && cnt_zero;
  assign cnt_load = we ? WrLoad : RdLoad;

  wait_state_ram_wait_counter #(
    .Width(CntWidth)
  ) u_wait_counter (
    .clk    (clk),
    .rst    (rst),
    .load_i (accept),
    .value_i(cnt_load),
    .dec_i  (state_q == WAIT),
    .zero_o (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = WAIT;
      WAIT:    if (cnt_zero) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      state_q    <= IDLE;
      op_q       <= OpRead;
      widx_q     <= '0;
      in_range_q <= 1'b0;
      wdata_q    <= '0;
      bslct_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q       <= we ? OpWrite : OpRead;
        widx_q     <= word_idx[IdxWidth-1:0];
        in_range_q <= addr_ok;
        wdata_q    <= data_i;
        bslct_q    <= byte_slct;
      end
      if (access && (op_q == OpRead)) begin
        rdata_q <= in_range_q ? mem_q[widx_q] : '0;
      end
    end
  end

  // Array is deliberately unreset; state_q gating makes a reset-aborted write a no-op.
  always_ff @(posedge clk) begin
    if (access && (op_q == OpWrite) && in_range_q) begin
      for (int i = 0; i < Lanes; i++) begin
        if (bslct_q[i]) begin
          mem_q[widx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign data_o  = rdata_q;
  assign ready_o = (state_q == DONE);
  assign busy_o  = (state_q == WAIT);
  assign err_o   = ready_o && !in_range_q;

endmodule

// File: tb/tb_wait_state_ram.sv
// Self-checking bench for wait_state_ram: 32-bit instance plus a 64-bit,
// single-cycle-latency instance, checked against a word-level memory model.
module tb_wait_state_ram;

  localparam int RD_LAT = 2;
  localparam int WR_LAT = 1;
  localparam int DEPTH  = 1024;
  localparam int TMO    = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce, we;
  logic [31:0] addr_i, data_i;
  logic [3:0]  byte_slct;
  logic [31:0] data_o;
  logic        ready_o, busy_o, err_o;

  logic        ce64, we64;
  logic [31:0] addr64;
  logic [63:0] data64_i, data64_o;
  logic [7:0]  bslct64;
  logic        ready64, busy64, err64;

  always #5 clk = ~clk;

  wait_state_ram #(
    .DataWidth(32), .Lanes(4), .Depth(DEPTH), .AddrWidth(32),
    .ReadLatency(RD_LAT), .WriteLatency(WR_LAT)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .addr_i(addr_i), .data_i(data_i),
    .byte_slct(byte_slct), .data_o(data_o), .ready_o(ready_o), .busy_o(busy_o),
    .err_o(err_o)
  );

  wait_state_ram #(
    .DataWidth(64), .Lanes(8), .Depth(64), .AddrWidth(32),
    .ReadLatency(1), .WriteLatency(1)
  ) dut64 (
    .clk(clk), .rst(rst), .ce(ce64), .we(we64), .addr_i(addr64), .data_i(data64_i),
    .byte_slct(bslct64), .data_o(data64_o), .ready_o(ready64), .busy_o(busy64),
    .err_o(err64)
  );

  int checks = 0;
  int errors = 0;

  // Reference: word-addressed array plus the last completed read value.
  logic [31:0] mem_model [int];
  logic [31:0] rd_model;

  function automatic logic [31:0] merge32(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] sel);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (sel[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  // Applies one access to the model and returns what the RAM must report.
  task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] b, output int exp_lat, output logic exp_err,
                              output logic [31:0] exp_data);
    int idx;
    logic ok;
    idx = int'(a / 4);
    ok  = (a / 4) < DEPTH;
    exp_err = !ok;
    if (w) begin
      exp_lat = WR_LAT;
      if (ok) mem_model[idx] = merge32(mem_model.exists(idx) ? mem_model[idx] : 32'h0, d, b);
    end else begin
      exp_lat  = RD_LAT;
      rd_model = ok ? mem_model[idx] : 32'h0;
    end
    exp_data = rd_model;
  endtask

  task automatic run_access(input logic w, input logic c, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] b,
                            output int lat, output int busy_n, output logic [31:0] dout,
                            output logic e, output logic busy_at_rdy);
    @(negedge clk);
    we = w; ce = c; addr_i = a; data_i = d; byte_slct = b;
    @(posedge clk); #1;
    lat = 0; busy_n = 0;
    while (!ready_o && lat < TMO) begin
      if (busy_o) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
    dout = data_o; e = err_o; busy_at_rdy = busy_o;
    we = 1'b0; ce = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_access64(input logic w, input logic [31:0] a, input logic [63:0] d,
                              input logic [7:0] b, output int lat, output logic [63:0] dout);
    @(negedge clk);
    we64 = w; ce64 = !w; addr64 = a; data64_i = d; bslct64 = b;
    @(posedge clk); #1;
    lat = 0;
    while (!ready64 && lat < TMO) begin
      @(posedge clk); #1;
      lat++;
    end
    dout = data64_o;
    we64 = 1'b0; ce64 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ce = 0; we = 0; addr_i = 0; data_i = 0; byte_slct = 0;
    ce64 = 0; we64 = 0; addr64 = 0; data64_i = 0; bslct64 = 0;
    rd_model = 32'h0;
    #12;
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_o); end
    checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", data_o); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_preload();
    int lat, bn, el; logic e, ee, br; logic [31:0] dout, ed, v;
    for (int i = 0; i < 32; i++) begin
      v = (i == 4) ? 32'hDEADBEEF : (i == 5) ? 32'h11223344 : $urandom;
      model_access(1'b1, 32'(i * 4), v, 4'hF, el, ee, ed);
      run_access(1'b1, 1'b0, 32'(i * 4), v, 4'hF, lat, bn, dout, e, br);
      checks++; if (lat !== el) begin errors++; $display("FAIL preload_lat[%0d]: got %0d expected %0d", i, lat, el); end
    end
  endtask

  task automatic test_basic_latency();
    int lat, bn, el; logic e, ee, br; logic [31:0] dout, ed;
    model_access(1'b0, 32'h10, 32'h0, 4'h0, el, ee, ed);
    run_access(1'b0, 1'b1, 32'h10, 32'h0, 4'h0, lat, bn, dout, e, br);
    checks++; if (lat !== RD_LAT) begin errors++; $display("FAIL basic_lat: got %0d expected %0d", lat, RD_LAT); end
    checks++; if (dout !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_data: got %h expected deadbeef", dout); end
    checks++; if (bn !== RD_LAT) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected %0d", bn, RD_LAT); end
    checks++; if (br !== 1'b0 || e !== 1'b0) begin errors++; $display("FAIL basic_busy_err_at_ready: got %b%b expected 00", br, e); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL basic_ready_pulse_width: got %b expected 0", ready_o); end
  endtask

  task automatic test_byte_write();
    int lat, bn, el; logic e, ee, br; logic [31:0] dout, ed;
    model_access(1'b1, 32'h14, 32'hAABBCCDD, 4'b0101, el, ee, ed);
    run_access(1'b1, 1'b0, 32'h14, 32'hAABBCCDD, 4'b0101, lat, bn, dout, e, br);
    checks++; if (lat !== WR_LAT) begin errors++; $display("FAIL bytewr_lat: got %0d expected %0d", lat, WR_LAT); end
    checks++; if (dout !== ed) begin errors++; $display("FAIL bytewr_data_o_held: got %h expected %h", dout, ed); end
    model_access(1'b0, 32'h14, 32'h0, 4'h0, el, ee, ed);
    run_access(1'b0, 1'b1, 32'h14, 32'h0, 4'h0, lat, bn, dout, e, br);
    checks++; if (dout !== 32'h11BB33DD) begin errors++; $display("FAIL bytewr_readback: got %h expected 11bb33dd", dout); end
    // Zero byte-enables: a legal write that leaves the word untouched.
    model_access(1'b1, 32'h14, 32'h0, 4'h0, el, ee, ed);
    run_access(1'b1, 1'b0, 32'h14, 32'h0, 4'h0, lat, bn, dout, e, br);
    model_access(1'b0, 32'h14, 32'h0, 4'h0, el, ee, ed);
    run_access(1'b0, 1'b1, 32'h14, 32'h0, 4'h0, lat, bn, dout, e, br);
    checks++; if (dout !== ed) begin errors++; $display("FAIL bytewr_zero_mask: got %h expected %h", dout, ed); end
  endtask

  task automatic test_priority_busy();
    int lat, bn, el, lat2; logic e, ee, br; logic [31:0] dout, ed;
    model_access(1'b1, 32'h20, 32'h5, 4'hF, el, ee, ed);
    run_access(1'b1, 1'b1, 32'h20, 32'h5, 4'hF, lat, bn, dout, e, br);
    checks++; if (lat !== WR_LAT) begin errors++; $display("FAIL prio_lat: got %0d expected %0d", lat, WR_LAT); end
    checks++; if (dout !== ed) begin errors++; $display("FAIL prio_data_o_held: got %h expected %h", dout, ed); end
    model_access(1'b0, 32'h20, 32'h0, 4'h0, el, ee, ed);
    run_access(1'b0, 1'b1, 32'h20, 32'h0, 4'h0, lat, bn, dout, e, br);
    checks++; if (dout !== 32'h5) begin errors++; $display("FAIL prio_readback: got %h expected 00000005", dout); end

    // Read accepted, then a write request raised while the read is in WAIT.
    @(negedge clk); ce = 1; we = 0; addr_i = 32'h10;
    @(posedge clk); #1;
    ce = 0; we = 1; addr_i = 32'h24; data_i = 32'h600DF00D; byte_slct = 4'hF;
    model_access(1'b0, 32'h10, 32'h0, 4'h0, el, ee, ed);
    lat = 0;
    while (!ready_o && lat < TMO) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== RD_LAT) begin errors++; $display("FAIL busy_first_lat: got %0d expected %0d", lat, RD_LAT); end
    checks++; if (data_o !== ed) begin errors++; $display("FAIL busy_first_data: got %h expected %h", data_o, ed); end
    @(posedge clk); #1;
    lat2 = 1;
    while (!ready_o && lat2 < TMO) begin @(posedge clk); #1; lat2++; end
    checks++; if (lat2 !== 2 + WR_LAT) begin errors++; $display("FAIL busy_second_gap: got %0d expected %0d", lat2, 2 + WR_LAT); end
    model_access(1'b1, 32'h24, 32'h600DF00D, 4'hF, el, ee, ed);
    checks++; if (data_o !== ed) begin errors++; $display("FAIL busy_second_data_held: got %h expected %h", data_o, ed); end
    we = 0;
    @(posedge clk); #1;
    model_access(1'b0, 32'h24, 32'h0, 4'h0, el, ee, ed);
    run_access(1'b0, 1'b1, 32'h24, 32'h0, 4'h0, lat, bn, dout, e, br);
    checks++; if (dout !== 32'h600DF00D) begin errors++; $display("FAIL busy_second_readback: got %h expected 600df00d", dout); end
  endtask

  task automatic test_out_of_range();
    int lat, bn, el; logic e, ee, br; logic [31:0] dout, ed;
    model_access(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, el, ee, ed);
    run_access(1'b1, 1'b0, 32'h1000, 32'hFFFFFFFF, 4'hF, lat, bn, dout, e, br);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_write_err: got %b expected 1", e); end
    checks++; if (dout !== ed) begin errors++; $display("FAIL oor_write_data_held: got %h expected %h", dout, ed); end
    model_access(1'b0, 32'h1000, 32'h0, 4'h0, el, ee, ed);
    run_access(1'b0, 1'b1, 32'h1000, 32'h0, 4'h0, lat, bn, dout, e, br);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_read_err: got %b expected 1", e); end
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL oor_read_data: got %h expected 0", dout); end
    checks++; if (lat !== RD_LAT) begin errors++; $display("FAIL oor_read_lat: got %0d expected %0d", lat, RD_LAT); end
    model_access(1'b0, 32'h0, 32'h0, 4'h0, el, ee, ed);
    run_access(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, lat, bn, dout, e, br);
    checks++; if (dout !== ed || e !== 1'b0) begin errors++; $display("FAIL oor_word0_intact: got %h/%b expected %h/0", dout, e, ed); end
    // Last in-range word, with low address bits set that must be ignored.
    model_access(1'b1, 32'(DEPTH * 4 - 1), 32'h0BADCAFE, 4'hF, el, ee, ed);
    run_access(1'b1, 1'b0, 32'(DEPTH * 4 - 1), 32'h0BADCAFE, 4'hF, lat, bn, dout, e, br);
    checks++; if (e !== ee) begin errors++; $display("FAIL edge_last_word_err: got %b expected %b", e, ee); end
  endtask

  task automatic test_random();
    int lat, bn, el; logic e, ee, br, w, c; logic [31:0] dout, ed, a, d; logic [3:0] b;
    int idx;
    for (int n = 0; n < 60; n++) begin
      w   = 1'($urandom_range(0, 1));
      c   = !w || ($urandom_range(0, 3) == 0);
      idx = ($urandom_range(0, 7) == 0) ? DEPTH + int'($urandom_range(0, 4000)) : int'($urandom_range(0, 31));
      a   = 32'(idx * 4) + 32'($urandom_range(0, 3));
      d   = $urandom;
      b   = 4'($urandom_range(0, 15));
      model_access(w, a, d, b, el, ee, ed);
      run_access(w, c, a, d, b, lat, bn, dout, e, br);
      checks++; if (lat !== el) begin errors++; $display("FAIL rand_lat[%0d]: got %0d expected %0d", n, lat, el); end
      checks++; if (bn !== el) begin errors++; $display("FAIL rand_busy[%0d]: got %0d expected %0d", n, bn, el); end
      checks++; if (e !== ee) begin errors++; $display("FAIL rand_err[%0d]: got %b expected %b", n, e, ee); end
      checks++; if (dout !== ed) begin errors++; $display("FAIL rand_data[%0d]: got %h expected %h", n, dout, ed); end
    end
  endtask

  task automatic test_reset_mid_access();
    int lat, bn, el; logic e, ee, br, seen; logic [31:0] dout, ed;
    @(negedge clk); ce = 1; we = 0; addr_i = 32'h10;
    @(posedge clk); #1;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b expected 1", busy_o); end
    #2 rst = 1'b0; #1;
    rd_model = 32'h0;
    checks++; if (busy_o !== 1'b0 || ready_o !== 1'b0 || err_o !== 1'b0) begin
      errors++; $display("FAIL rstmid_flags: got busy %b ready %b err %b expected 0 0 0", busy_o, ready_o, err_o);
    end
    checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL rstmid_data: got %h expected 0", data_o); end
    @(negedge clk); ce = 0; rst = 1'b1;
    seen = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (ready_o) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_ready: got %b expected 0", seen); end
    // Aborted write must leave word 6 untouched.
    @(negedge clk); we = 1; addr_i = 32'h18; data_i = 32'hCAFEF00D; byte_slct = 4'hF;
    @(posedge clk); #1;
    #2 rst = 1'b0;
    @(negedge clk); we = 0; rst = 1'b1;
    @(posedge clk); #1;
    model_access(1'b0, 32'h18, 32'h0, 4'h0, el, ee, ed);
    run_access(1'b0, 1'b1, 32'h18, 32'h0, 4'h0, lat, bn, dout, e, br);
    checks++; if (dout !== ed) begin errors++; $display("FAIL rstmid_write_aborted: got %h expected %h", dout, ed); end
  endtask

  task automatic test_wide();
    int lat; logic [63:0] dout, w0, d1, exp_w;
    w0 = {$urandom, $urandom};
    d1 = {$urandom, $urandom};
    run_access64(1'b1, 32'd24, w0, 8'hFF, lat, dout);
    checks++; if (lat !== 1) begin errors++; $display("FAIL wide_write_lat: got %0d expected 1", lat); end
    run_access64(1'b0, 32'd24, 64'h0, 8'h00, lat, dout);
    checks++; if (lat !== 1) begin errors++; $display("FAIL wide_read_lat: got %0d expected 1", lat); end
    checks++; if (dout !== w0) begin errors++; $display("FAIL wide_read_data: got %h expected %h", dout, w0); end
    run_access64(1'b1, 32'd24, d1, 8'h80, lat, dout);
    exp_w = {d1[63:56], w0[55:0]};
    run_access64(1'b0, 32'd24, 64'h0, 8'h00, lat, dout);
    checks++; if (dout !== exp_w) begin errors++; $display("FAIL wide_top_lane: got %h expected %h", dout, exp_w); end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_basic_latency();
    test_byte_write();
    test_priority_busy();
    test_out_of_range();
    test_random();
    test_reset_mid_access();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
